// File: rtl/video_timing_detect.sv
// Measures raster timing (H/V total, active, sync width) from hs/vs/de and reports lock.
// Frame commit at each vs rise; outputs update three clocks after vs reaches the input pins.
module video_timing_detect #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             positive_hsync,
  input  logic             positive_vsync,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  output logic [CNT_W-1:0] htotal,
  output logic [CNT_W-1:0] hactive,
  output logic [CNT_W-1:0] hsync_width,
  output logic [CNT_W-1:0] vtotal,
  output logic [CNT_W-1:0] vactive,
  output logic [CNT_W-1:0] vsync_width,
  output logic             valid,
  output logic             changed
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] hline;
    logic [CNT_W-1:0] hact;
    logic [CNT_W-1:0] hsw;
    logic [CNT_W-1:0] vline;
    logic [CNT_W-1:0] vact;
    logic [CNT_W-1:0] vsw;
  } timing_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic w_hs_a, w_vs_a;
  logic r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2, r_de_s1, r_de_s2;
  logic w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;

  logic [CNT_W-1:0] r_hcnt, r_hline, r_hsw, r_hsw_l, r_dew, r_hact_l;
  logic [CNT_W-1:0] r_vcnt, r_vline, r_vsw, r_vsw_l, r_vact, r_vact_l;
  logic             r_commit;

  timing_t w_cand, r_prev;
  state_t  r_state;
  logic    w_timeout, w_cand_sat;

  assign w_hs_a = ~(hs ^ positive_hsync);
  assign w_vs_a = ~(vs ^ positive_vsync);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_s1 <= 1'b0;
      r_hs_s2 <= 1'b0;
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_de_s1 <= 1'b0;
      r_de_s2 <= 1'b0;
    end else begin
      r_hs_s1 <= w_hs_a;
      r_hs_s2 <= r_hs_s1;
      r_vs_s1 <= w_vs_a;
      r_vs_s2 <= r_vs_s1;
      r_de_s1 <= de;
      r_de_s2 <= r_de_s1;
    end
  end

  assign w_hs_rise = r_hs_s1 & ~r_hs_s2;
  assign w_hs_fall = ~r_hs_s1 & r_hs_s2;
  assign w_vs_rise = r_vs_s1 & ~r_vs_s2;
  assign w_vs_fall = ~r_vs_s1 & r_vs_s2;
  assign w_de_rise = r_de_s1 & ~r_de_s2;
  assign w_de_fall = ~r_de_s1 & r_de_s2;

  // Edges coinciding with a vs rise are credited to the frame that starts there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt   <= '0;
      r_hline  <= '0;
      r_hsw    <= '0;
      r_hsw_l  <= '0;
      r_dew    <= '0;
      r_hact_l <= '0;
      r_vcnt   <= '0;
      r_vline  <= '0;
      r_vsw    <= '0;
      r_vsw_l  <= '0;
      r_vact   <= '0;
      r_vact_l <= '0;
      r_commit <= 1'b0;
    end else begin
      if (w_hs_rise) begin
        r_hline <= r_hcnt;
        r_hcnt  <= ONE;
      end else if (r_hcnt != MAX) begin
        r_hcnt <= r_hcnt + ONE;
      end

      if (w_hs_fall) begin
        r_hsw_l <= r_hsw;
        r_hsw   <= '0;
      end else if (r_hs_s1 && r_hsw != MAX) begin
        r_hsw <= r_hsw + ONE;
      end

      if (w_de_fall) begin
        r_hact_l <= r_dew;
        r_dew    <= '0;
      end else if (r_de_s1 && r_dew != MAX) begin
        r_dew <= r_dew + ONE;
      end

      if (w_vs_rise) begin
        r_vline <= r_vcnt;
        r_vcnt  <= w_hs_rise ? ONE : '0;
      end else if (w_hs_rise && r_vcnt != MAX) begin
        r_vcnt <= r_vcnt + ONE;
      end

      if (w_vs_fall) begin
        r_vsw_l <= r_vsw;
        r_vsw   <= '0;
      end else if (w_hs_rise && r_vs_s1 && r_vsw != MAX) begin
        r_vsw <= r_vsw + ONE;
      end

      if (w_vs_rise) begin
        r_vact_l <= r_vact;
        r_vact   <= w_de_rise ? ONE : '0;
      end else if (w_de_rise && r_vact != MAX) begin
        r_vact <= r_vact + ONE;
      end

      r_commit <= w_vs_rise;
    end
  end

  assign w_cand     = {r_hline, r_hact_l, r_hsw_l, r_vline, r_vact_l, r_vsw_l};
  assign w_timeout  = (r_hcnt == MAX) || (r_vcnt == MAX);
  assign w_cand_sat = (r_hline == MAX) || (r_vline == MAX);

  // Commit runs one cycle after the vs rise so the latched tuple is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_prev      <= '0;
      htotal      <= '0;
      hactive     <= '0;
      hsync_width <= '0;
      vtotal      <= '0;
      vactive     <= '0;
      vsync_width <= '0;
      valid       <= 1'b0;
      changed     <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (w_timeout) begin
        r_state     <= SEARCH;
        htotal      <= '0;
        hactive     <= '0;
        hsync_width <= '0;
        vtotal      <= '0;
        vactive     <= '0;
        vsync_width <= '0;
        valid       <= 1'b0;
        changed     <= valid;
      end else if (r_commit) begin
        case (r_state)
          SEARCH: begin
            r_prev  <= w_cand;
            r_state <= MEASURE;
          end
          MEASURE: begin
            if (w_cand == r_prev && !w_cand_sat) begin
              htotal      <= w_cand.hline;
              hactive     <= w_cand.hact;
              hsync_width <= w_cand.hsw;
              vtotal      <= w_cand.vline;
              vactive     <= w_cand.vact;
              vsync_width <= w_cand.vsw;
              valid       <= 1'b1;
              r_state     <= LOCKED;
            end else begin
              r_prev <= w_cand;
            end
          end
          LOCKED: begin
            if (w_cand != r_prev) begin
              valid   <= 1'b0;
              changed <= 1'b1;
              r_prev  <= w_cand;
              r_state <= MEASURE;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect: lock, polarity, timing change, timeout, reset, coincident edges.
module tb_video_timing_detect;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             positive_hsync, positive_vsync;
  logic             hs, vs, de;
  logic [CNT_W-1:0] htotal, hactive, hsync_width, vtotal, vactive, vsync_width;
  logic             valid, changed;

  video_timing_detect #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .positive_hsync(positive_hsync),
    .positive_vsync(positive_vsync),
    .hs            (hs),
    .vs            (vs),
    .de            (de),
    .htotal        (htotal),
    .hactive       (hactive),
    .hsync_width   (hsync_width),
    .vtotal        (vtotal),
    .vactive       (vactive),
    .vsync_width   (vsync_width),
    .valid         (valid),
    .changed       (changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int vs_count = 0, last_vs_cyc = 0, lock_vs_n = 0, lock_lat = 0;
  int chg_pulses = 0, chg_cycles = 0;
  logic valid_q = 1'b0, changed_q = 1'b0;
  bit   prev_vs_a = 1'b0;
  int   g_hact, g_htot, g_hs_start, g_vs_start;
  bit   g_pol;
  int   c0, c1;

  // Lock time is recorded relative to the most recent vs assertion driven.
  always @(negedge clk) begin
    if (valid === 1'b1 && valid_q === 1'b0) begin
      lock_vs_n = vs_count;
      lock_lat  = cyc - last_vs_cyc;
    end
    if (changed === 1'b1) chg_cycles++;
    if (changed === 1'b1 && changed_q !== 1'b1) chg_pulses++;
    valid_q   = valid;
    changed_q = changed;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_timing(input string p, input int ht, input int ha, input int hw,
                            input int vt, input int va, input int vw);
    chk({p, ".htotal"},      32'(htotal),      ht);
    chk({p, ".hactive"},     32'(hactive),     ha);
    chk({p, ".hsync_width"}, 32'(hsync_width), hw);
    chk({p, ".vtotal"},      32'(vtotal),      vt);
    chk({p, ".vactive"},     32'(vactive),     va);
    chk({p, ".vsync_width"}, 32'(vsync_width), vw);
  endtask

  task automatic set_h(input int act);
    g_hact     = act;
    g_htot     = act + 9;
    g_hs_start = act + 2;
  endtask

  task automatic drive_line(input int y);
    bit hs_a, vs_a;
    for (int x = 0; x < g_htot; x++) begin
      @(posedge clk);
      #1;
      hs_a = (x >= g_hs_start) && (x < g_hs_start + 3);
      vs_a = (y >= g_vs_start) && (y < g_vs_start + 2);
      de   = (x < g_hact) && (y < 8);
      hs   = g_pol ? hs_a : !hs_a;
      vs   = g_pol ? vs_a : !vs_a;
      if (vs_a && !prev_vs_a) begin
        vs_count++;
        last_vs_cyc = cyc;
      end
      prev_vs_a = vs_a;
    end
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < 14; y++) drive_line(y);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    positive_hsync = g_pol;
    positive_vsync = g_pol;
    hs             = !g_pol;
    vs             = !g_pol;
    de             = 1'b0;
    prev_vs_a      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    vs_count  = 0;
    lock_vs_n = 0;
  endtask

  initial begin
    rst = 1'b1;
    hs = 1'b0; vs = 1'b0; de = 1'b0;
    positive_hsync = 1'b1; positive_vsync = 1'b1;
    g_pol = 1'b1;
    g_vs_start = 9;
    set_h(16);

    // Reset state
    do_reset();
    chk("rst.valid", 32'(valid), 0);
    chk("rst.changed", 32'(changed), 0);
    chk_timing("rst", 0, 0, 0, 0, 0, 0);

    // Positive polarity: lock on third vs rise, three clocks after vs
    c0 = chg_pulses;
    frames(3);
    chk("pos.valid", 32'(valid), 1);
    chk("pos.lock_vs", lock_vs_n, 3);
    chk("pos.lock_lat", lock_lat, 3);
    chk_timing("pos", 25, 16, 3, 14, 8, 2);
    chk("pos.no_changed", chg_pulses - c0, 0);

    // Negative polarity with inverted syncs
    g_pol = 1'b0;
    do_reset();
    c0 = chg_pulses;
    frames(3);
    chk("neg.valid", 32'(valid), 1);
    chk("neg.lock_vs", lock_vs_n, 3);
    chk("neg.lock_lat", lock_lat, 3);
    chk_timing("neg", 25, 16, 3, 14, 8, 2);
    chk("neg.no_changed", chg_pulses - c0, 0);

    // Timing change while locked
    set_h(20);
    c0 = chg_pulses;
    c1 = chg_cycles;
    frames(1);
    chk("chg.valid_drop", 32'(valid), 0);
    chk("chg.pulses", chg_pulses - c0, 1);
    chk("chg.pulse_len", chg_cycles - c1, 1);
    frames(1);
    chk("chg.relock", 32'(valid), 1);
    chk_timing("chg", 29, 20, 3, 14, 8, 2);

    // vs held off until vcnt saturates
    c0 = chg_pulses;
    c1 = chg_cycles;
    repeat (260) drive_line(13);
    chk("tmo.valid", 32'(valid), 0);
    chk_timing("tmo", 0, 0, 0, 0, 0, 0);
    chk("tmo.pulses", chg_pulses - c0, 1);
    chk("tmo.pulse_len", chg_cycles - c1, 1);
    vs_count  = 0;
    lock_vs_n = 0;
    frames(3);
    chk("tmo.relock", 32'(valid), 1);
    chk("tmo.relock_vs", lock_vs_n, 3);
    chk("tmo.htotal", 32'(htotal), 29);

    // One-cycle reset in the middle of a frame
    for (int y = 0; y < 3; y++) drive_line(y);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vs_count  = 0;
    lock_vs_n = 0;
    chk("mrst.valid", 32'(valid), 0);
    chk("mrst.changed", 32'(changed), 0);
    chk("mrst.htotal", 32'(htotal), 0);
    chk("mrst.vtotal", 32'(vtotal), 0);
    for (int y = 3; y < 14; y++) drive_line(y);
    frames(1);
    chk("mrst.no_lock_2vs", 32'(valid), 0);
    frames(1);
    chk("mrst.valid3", 32'(valid), 1);
    chk("mrst.lock_vs", lock_vs_n, 3);

    // vs rise coincident with hs rise and de rise
    g_pol = 1'b1;
    set_h(16);
    g_hs_start = 0;
    g_vs_start = 0;
    do_reset();
    frames(3);
    chk("coin.valid", 32'(valid), 1);
    chk("coin.lock_vs", lock_vs_n, 3);
    chk_timing("coin", 25, 16, 3, 14, 8, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
